// File: rtl/axi_shim_arb_pkg.sv
// Shared types and constants for the axi_shim port arbiter.
// Port numbering matches the order in which requesters are wired to the arbiter.
package axi_shim_arb_pkg;

    localparam int unsigned PORT_ICACHE = 0;
    localparam int unsigned PORT_DCACHE = 1;
    localparam int unsigned PORT_BYPASS = 2;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/axi_shim_rr_lock.sv
// Round-robin picker that locks onto the presented port until the shim grants it,
// so a command is never withdrawn or swapped while the shim is still considering it.
module axi_shim_rr_lock
    import axi_shim_arb_pkg::*;
#(
    parameter int unsigned NumPorts = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumPorts-1:0]         eligible_i,
    input  logic                        gnt_i,
    output logic [$clog2(NumPorts)-1:0] sel_o,
    output logic                        sel_valid_o,
    output logic                        hold_o
);

    localparam int unsigned PW = $clog2(NumPorts);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] lock_q, lock_d;
    logic [PW-1:0] pick;
    logic [PW-1:0] cand;
    logic          pick_found;

    // Search starts one past the last winner so every port gets its turn.
    always_comb begin
        pick       = '0;
        cand       = '0;
        pick_found = 1'b0;
        for (int k = 1; k <= int'(NumPorts); k++) begin
            cand = PW'((int'(ptr_q) + k) % int'(NumPorts));
            if (!pick_found && eligible_i[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lock_d      = lock_q;
        sel_o       = pick;
        sel_valid_o = pick_found;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    if (gnt_i) begin
                        ptr_d = pick;
                    end else begin
                        lock_d  = pick;
                        state_d = ARB_HOLD;
                    end
                end
            end
            ARB_HOLD: begin
                sel_o       = lock_q;
                sel_valid_o = 1'b1;
                if (gnt_i) begin
                    ptr_d   = lock_q;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign hold_o = (state_q == ARB_HOLD);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ARB_IDLE;
            ptr_q   <= PW'(NumPorts - 1);
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
        end
    end

endmodule

// File: rtl/axi_shim_port_arbiter.sv
// Shares one axi_shim among several requesters: independent read/write arbitration,
// port-tagged IDs for response steering, and per-port outstanding limits.
module axi_shim_port_arbiter
    import axi_shim_arb_pkg::*;
#(
    parameter int unsigned NumPorts    = 3,
    parameter int unsigned AxiNumWords = 4,
    parameter int unsigned AxiIdWidth  = 4,
    parameter int unsigned MaxRdOut    = 4,
    parameter int unsigned MaxWrOut    = 4
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_ni,
    input  logic [NumPorts-1:0]                                  rd_req_i,
    output logic [NumPorts-1:0]                                  rd_gnt_o,
    input  logic [NumPorts-1:0][63:0]                            rd_addr_i,
    input  logic [NumPorts-1:0][$clog2(AxiNumWords)-1:0]         rd_blen_i,
    input  logic [NumPorts-1:0][1:0]                             rd_size_i,
    input  logic [NumPorts-1:0][AxiIdWidth-$clog2(NumPorts)-1:0] rd_id_i,
    input  logic [NumPorts-1:0]                                  rd_lock_i,
    input  logic [NumPorts-1:0]                                  rd_rdy_i,
    output logic [NumPorts-1:0]                                  rd_valid_o,
    output logic [NumPorts-1:0]                                  rd_last_o,
    output logic [63:0]                                          rd_data_o,
    output logic [AxiIdWidth-$clog2(NumPorts)-1:0]               rd_id_o,
    output logic                                                 rd_exokay_o,
    input  logic [NumPorts-1:0]                                  wr_req_i,
    output logic [NumPorts-1:0]                                  wr_gnt_o,
    input  logic [NumPorts-1:0][63:0]                            wr_addr_i,
    input  logic [NumPorts-1:0][AxiNumWords-1:0][63:0]           wr_data_i,
    input  logic [NumPorts-1:0][AxiNumWords-1:0][7:0]            wr_be_i,
    input  logic [NumPorts-1:0][$clog2(AxiNumWords)-1:0]         wr_blen_i,
    input  logic [NumPorts-1:0][1:0]                             wr_size_i,
    input  logic [NumPorts-1:0][AxiIdWidth-$clog2(NumPorts)-1:0] wr_id_i,
    input  logic [NumPorts-1:0]                                  wr_lock_i,
    input  logic [NumPorts-1:0][5:0]                             wr_atop_i,
    input  logic [NumPorts-1:0]                                  wr_rdy_i,
    output logic [NumPorts-1:0]                                  wr_valid_o,
    output logic [AxiIdWidth-$clog2(NumPorts)-1:0]               wr_id_o,
    output logic                                                 wr_exokay_o,
    output logic                                                 shim_rd_req_o,
    input  logic                                                 shim_rd_gnt_i,
    output logic [63:0]                                          shim_rd_addr_o,
    output logic [$clog2(AxiNumWords)-1:0]                       shim_rd_blen_o,
    output logic [1:0]                                           shim_rd_size_o,
    output logic [AxiIdWidth-1:0]                                shim_rd_id_o,
    output logic                                                 shim_rd_lock_o,
    output logic                                                 shim_rd_rdy_o,
    input  logic                                                 shim_rd_valid_i,
    input  logic                                                 shim_rd_last_i,
    input  logic [63:0]                                          shim_rd_data_i,
    input  logic [AxiIdWidth-1:0]                                shim_rd_id_i,
    input  logic                                                 shim_rd_exokay_i,
    output logic                                                 shim_wr_req_o,
    input  logic                                                 shim_wr_gnt_i,
    output logic [63:0]                                          shim_wr_addr_o,
    output logic [AxiNumWords-1:0][63:0]                         shim_wr_data_o,
    output logic [AxiNumWords-1:0][7:0]                          shim_wr_be_o,
    output logic [$clog2(AxiNumWords)-1:0]                       shim_wr_blen_o,
    output logic [1:0]                                           shim_wr_size_o,
    output logic [AxiIdWidth-1:0]                                shim_wr_id_o,
    output logic                                                 shim_wr_lock_o,
    output logic [5:0]                                           shim_wr_atop_o,
    output logic                                                 shim_wr_rdy_o,
    input  logic                                                 shim_wr_valid_i,
    input  logic [AxiIdWidth-1:0]                                shim_wr_id_i,
    input  logic                                                 shim_wr_exokay_i
);

    localparam int unsigned PW  = $clog2(NumPorts);
    localparam int unsigned RW  = AxiIdWidth - PW;
    localparam int unsigned CRW = $clog2(MaxRdOut + 1);
    localparam int unsigned CWW = $clog2(MaxWrOut + 1);

    logic [PW-1:0]                rd_sel, wr_sel;
    logic                         rd_sel_valid, wr_sel_valid;
    logic                         rd_hold, wr_hold;
    logic [NumPorts-1:0]          rd_eligible, wr_eligible;
    logic [NumPorts-1:0]          rd_dec, wr_dec;
    logic [NumPorts-1:0]          rd_cnt_err, wr_cnt_err;
    logic                         rd_rsp_known, wr_rsp_known;
    logic [PW-1:0]                rd_rsp_port, wr_rsp_port;
    logic [NumPorts-1:0][CRW-1:0] rd_cnt_q, rd_cnt_d;
    logic [NumPorts-1:0][CWW-1:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_eligible = '0;
        wr_eligible = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            rd_eligible[i] = rd_req_i[i] && (rd_cnt_q[i] < CRW'(MaxRdOut));
            wr_eligible[i] = wr_req_i[i] && (wr_cnt_q[i] < CWW'(MaxWrOut));
        end
    end

    axi_shim_rr_lock #(.NumPorts(NumPorts)) i_rd_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .eligible_i  (rd_eligible),
        .gnt_i       (shim_rd_gnt_i & shim_rd_req_o),
        .sel_o       (rd_sel),
        .sel_valid_o (rd_sel_valid),
        .hold_o      (rd_hold)
    );

    axi_shim_rr_lock #(.NumPorts(NumPorts)) i_wr_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .eligible_i  (wr_eligible),
        .gnt_i       (shim_wr_gnt_i & shim_wr_req_o),
        .sel_o       (wr_sel),
        .sel_valid_o (wr_sel_valid),
        .hold_o      (wr_hold)
    );

    // The port index rides in the top ID bits so responses find their way home.
    assign shim_rd_req_o  = rd_sel_valid & rst_ni;
    assign shim_rd_addr_o = rd_addr_i[rd_sel];
    assign shim_rd_blen_o = rd_blen_i[rd_sel];
    assign shim_rd_size_o = rd_size_i[rd_sel];
    assign shim_rd_id_o   = {rd_sel, rd_id_i[rd_sel]};
    assign shim_rd_lock_o = rd_lock_i[rd_sel];

    assign shim_wr_req_o  = wr_sel_valid & rst_ni;
    assign shim_wr_addr_o = wr_addr_i[wr_sel];
    assign shim_wr_data_o = wr_data_i[wr_sel];
    assign shim_wr_be_o   = wr_be_i[wr_sel];
    assign shim_wr_blen_o = wr_blen_i[wr_sel];
    assign shim_wr_size_o = wr_size_i[wr_sel];
    assign shim_wr_id_o   = {wr_sel, wr_id_i[wr_sel]};
    assign shim_wr_lock_o = wr_lock_i[wr_sel];
    assign shim_wr_atop_o = wr_atop_i[wr_sel];

    always_comb begin
        rd_gnt_o = '0;
        wr_gnt_o = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            rd_gnt_o[i] = shim_rd_req_o && shim_rd_gnt_i && (rd_sel == PW'(i));
            wr_gnt_o[i] = shim_wr_req_o && shim_wr_gnt_i && (wr_sel == PW'(i));
        end
    end

    assign rd_rsp_port = shim_rd_id_i[AxiIdWidth-1:RW];
    assign wr_rsp_port = shim_wr_id_i[AxiIdWidth-1:RW];
    assign rd_data_o   = shim_rd_data_i;
    assign rd_id_o     = shim_rd_id_i[RW-1:0];
    assign rd_exokay_o = shim_rd_exokay_i;
    assign wr_id_o     = shim_wr_id_i[RW-1:0];
    assign wr_exokay_o = shim_wr_exokay_i;

    // Responses tagged with a nonexistent port are accepted and dropped so the shim never stalls.
    always_comb begin
        rd_valid_o    = '0;
        rd_last_o     = '0;
        rd_dec        = '0;
        rd_rsp_known  = 1'b0;
        shim_rd_rdy_o = 1'b1;
        wr_valid_o    = '0;
        wr_dec        = '0;
        wr_rsp_known  = 1'b0;
        shim_wr_rdy_o = 1'b1;
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (rd_rsp_port == PW'(i)) begin
                rd_rsp_known  = 1'b1;
                rd_valid_o[i] = shim_rd_valid_i & rst_ni;
                rd_last_o[i]  = shim_rd_valid_i & shim_rd_last_i & rst_ni;
                rd_dec[i]     = shim_rd_valid_i & shim_rd_last_i & rd_rdy_i[i];
                shim_rd_rdy_o = rd_rdy_i[i];
            end
            if (wr_rsp_port == PW'(i)) begin
                wr_rsp_known  = 1'b1;
                wr_valid_o[i] = shim_wr_valid_i & rst_ni;
                wr_dec[i]     = shim_wr_valid_i & wr_rdy_i[i];
                shim_wr_rdy_o = wr_rdy_i[i];
            end
        end
    end

    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        rd_cnt_err = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (rd_gnt_o[i] && !rd_dec[i]) begin
                if (rd_cnt_q[i] == CRW'(MaxRdOut)) rd_cnt_err[i] = 1'b1;
                else                               rd_cnt_d[i]   = rd_cnt_q[i] + 1'b1;
            end else if (rd_dec[i] && !rd_gnt_o[i]) begin
                if (rd_cnt_q[i] == '0) rd_cnt_err[i] = 1'b1;
                else                   rd_cnt_d[i]   = rd_cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        wr_cnt_err = '0;
        for (int i = 0; i < int'(NumPorts); i++) begin
            if (wr_gnt_o[i] && !wr_dec[i]) begin
                if (wr_cnt_q[i] == CWW'(MaxWrOut)) wr_cnt_err[i] = 1'b1;
                else                               wr_cnt_d[i]   = wr_cnt_q[i] + 1'b1;
            end else if (wr_dec[i] && !wr_gnt_o[i]) begin
                if (wr_cnt_q[i] == '0) wr_cnt_err[i] = 1'b1;
                else                   wr_cnt_d[i]   = wr_cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    a_rd_hold_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rd_hold |-> rd_req_i[rd_sel]);
    a_wr_hold_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wr_hold |-> wr_req_i[wr_sel]);
    a_rd_rsp_port: assert property (@(posedge clk_i) disable iff (!rst_ni)
        shim_rd_valid_i |-> rd_rsp_known);
    a_wr_rsp_port: assert property (@(posedge clk_i) disable iff (!rst_ni)
        shim_wr_valid_i |-> wr_rsp_known);
    a_rd_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rd_cnt_err == '0);
    a_wr_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wr_cnt_err == '0);

endmodule
